// File: rtl/spectral_peak_detect.sv
// Per-frame peak search over a window of float32 squared-magnitude bins.
// Reports {peak value, bin, nan_seen} on an AXI4-Stream-style master port.
module spectral_peak_detect #(
   parameter int NFFT_LOG2 = 10,
   parameter int MIN_BIN   = 1,
   parameter int MAX_BIN   = 512
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [31:0]          s_axis_mag_tdata,
   input  logic                 s_axis_mag_tvalid,
   output logic                 s_axis_mag_tready,
   input  logic                 frame_sync,
   output logic [31:0]          m_axis_peak_tdata,
   output logic [NFFT_LOG2:0]   m_axis_peak_tuser,
   output logic                 m_axis_peak_tvalid,
   input  logic                 m_axis_peak_tready,
   output logic [15:0]          frame_count
);

   localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;
   localparam logic [NFFT_LOG2-1:0] MIN_IDX  = NFFT_LOG2'(MIN_BIN);
   localparam logic [NFFT_LOG2-1:0] MAX_IDX  = NFFT_LOG2'(MAX_BIN);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               state;
   logic [NFFT_LOG2-1:0] bin_cnt, best_bin;
   logic [30:0]          best_val;
   logic                 nan_seen;

   logic [NFFT_LOG2-1:0] bin, base_bin, nxt_bin;
   logic [30:0]          base_val, nxt_val, mag;
   logic                 base_nan, nxt_nan;
   logic                 accept, in_window, is_nan, last_beat;

   assign s_axis_mag_tready = (state == ACCUM) && !areset;

   // frame_sync restarts the frame from init values; a same-cycle beat becomes bin 0.
   always_comb begin
      accept    = s_axis_mag_tvalid && (state == ACCUM);
      bin       = frame_sync ? '0 : bin_cnt;
      base_val  = frame_sync ? '0 : best_val;
      base_bin  = frame_sync ? MIN_IDX : best_bin;
      base_nan  = frame_sync ? 1'b0 : nan_seen;
      in_window = (bin >= MIN_IDX) && (bin <= MAX_IDX);
      is_nan    = (s_axis_mag_tdata[30:23] == 8'hFF) && (s_axis_mag_tdata[22:0] != '0);
      mag       = s_axis_mag_tdata[31] ? '0 : s_axis_mag_tdata[30:0];
      last_beat = accept && (bin == LAST_IDX);
      nxt_val   = base_val;
      nxt_bin   = base_bin;
      nxt_nan   = base_nan;
      if (accept && in_window) begin
         if (is_nan) begin
            nxt_nan = 1'b1;
         end else if (mag > base_val) begin
            nxt_val = mag;
            nxt_bin = bin;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state              <= ACCUM;
         bin_cnt            <= '0;
         best_val           <= '0;
         best_bin           <= MIN_IDX;
         nan_seen           <= 1'b0;
         m_axis_peak_tvalid <= 1'b0;
         m_axis_peak_tdata  <= '0;
         m_axis_peak_tuser  <= '0;
         frame_count        <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (last_beat) begin
                  m_axis_peak_tdata  <= {1'b0, nxt_val};
                  m_axis_peak_tuser  <= {nxt_nan, nxt_bin};
                  m_axis_peak_tvalid <= 1'b1;
                  state              <= HOLD;
                  bin_cnt            <= '0;
                  best_val           <= '0;
                  best_bin           <= MIN_IDX;
                  nan_seen           <= 1'b0;
               end else begin
                  bin_cnt  <= accept ? bin + 1'b1 : bin;
                  best_val <= nxt_val;
                  best_bin <= nxt_bin;
                  nan_seen <= nxt_nan;
               end
            end
            HOLD: begin
               if (m_axis_peak_tready) begin
                  m_axis_peak_tvalid <= 1'b0;
                  frame_count        <= frame_count + 16'd1;
                  state              <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_spectral_peak_detect.sv
// Directed bench for spectral_peak_detect with N=8, window bins 1..4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_spectral_peak_detect;

   localparam int NL = 3;

   logic          aclk = 1'b0;
   logic          areset;
   logic [31:0]   s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic          frame_sync;
   logic [31:0]   m_tdata;
   logic [NL:0]   m_tuser;
   logic          m_tvalid;
   logic          m_tready;
   logic [15:0]   frame_count;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   frame [8];

   spectral_peak_detect #(.NFFT_LOG2(NL), .MIN_BIN(1), .MAX_BIN(4)) dut (
      .aclk               (aclk),
      .areset             (areset),
      .s_axis_mag_tdata   (s_tdata),
      .s_axis_mag_tvalid  (s_tvalid),
      .s_axis_mag_tready  (s_tready),
      .frame_sync         (frame_sync),
      .m_axis_peak_tdata  (m_tdata),
      .m_axis_peak_tuser  (m_tuser),
      .m_axis_peak_tvalid (m_tvalid),
      .m_axis_peak_tready (m_tready),
      .frame_count        (frame_count)
   );

   // clock / reset block
   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // driver tasks
   task automatic send_beat(input logic [31:0] d, input logic sync);
      s_tdata    = d;
      s_tvalid   = 1'b1;
      frame_sync = sync;
      @(posedge aclk); #1;
      s_tvalid   = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic run_frame();
      for (int i = 0; i < 8; i++) send_beat(frame[i], 1'b0);
   endtask

   task automatic set_frame(input logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7);
      frame[0] = b0; frame[1] = b1; frame[2] = b2; frame[3] = b3;
      frame[4] = b4; frame[5] = b5; frame[6] = b6; frame[7] = b7;
   endtask

   task automatic expect_result(input string tag, input logic [31:0] d, input logic [31:0] u,
                                input logic [31:0] fc);
      check_eq({tag, "_tvalid"}, {31'b0, m_tvalid}, 32'd1);
      check_eq({tag, "_tdata"},  m_tdata, d);
      check_eq({tag, "_tuser"},  {28'b0, m_tuser}, u);
      check_eq({tag, "_s_tready_low"}, {31'b0, s_tready}, 32'd0);
      @(posedge aclk); #1;
      check_eq({tag, "_tvalid_drop"}, {31'b0, m_tvalid}, 32'd0);
      check_eq({tag, "_frame_count"}, {16'b0, frame_count}, fc);
      check_eq({tag, "_s_tready_back"}, {31'b0, s_tready}, 32'd1);
   endtask

   initial begin
      areset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; frame_sync = 1'b0; m_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check_eq("rst_s_tready", {31'b0, s_tready}, 32'd0);
      areset = 1'b0;
      #1;
      check_eq("rst_s_tready_rel", {31'b0, s_tready}, 32'd1);
      check_eq("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
      check_eq("rst_tdata", m_tdata, 32'd0);
      check_eq("rst_tuser", {28'b0, m_tuser}, 32'd0);
      check_eq("rst_frame_count", {16'b0, frame_count}, 32'd0);
      @(posedge aclk); #1;

      // basic peak: bin 0 and bin 6 are outside the window
      set_frame(32'h4000_0000, 32'h3F80_0000, 0, 32'h4080_0000, 0, 0, 32'h4100_0000, 0);
      run_frame();
      expect_result("basic", 32'h4080_0000, 32'h3, 32'd1);

      // tie: lowest bin wins; bin 4 is inclusive
      set_frame(0, 0, 32'h4100_0000, 0, 32'h4100_0000, 0, 0, 0);
      run_frame();
      expect_result("tie", 32'h4100_0000, 32'h2, 32'd2);

      set_frame(0, 0, 0, 0, 0, 0, 0, 0);
      run_frame();
      expect_result("empty", 32'h0, 32'h1, 32'd3);

      // negative treated as zero, in-window NaN flagged and skipped
      set_frame(0, 32'hC000_0000, 32'h7FC0_0000, 32'h3F80_0000, 0, 32'h7FC0_0000, 0, 0);
      run_frame();
      expect_result("special", 32'h3F80_0000, 32'hB, 32'd4);

      set_frame(0, 0, 0, 0, 0, 32'h7FC0_0000, 0, 0);
      run_frame();
      expect_result("nan_out", 32'h0, 32'h1, 32'd5);

      // +Inf beats the largest finite value
      set_frame(0, 0, 0, 32'h7F7F_FFFF, 32'h7F80_0000, 0, 0, 0);
      run_frame();
      expect_result("inf", 32'h7F80_0000, 32'h4, 32'd6);

      // backpressure: result held for 5 cycles
      m_tready = 1'b0;
      set_frame(0, 32'h3F80_0000, 0, 0, 0, 0, 0, 0);
      run_frame();
      check_eq("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 32'h4200_0000;
         @(posedge aclk); #1;
         check_eq("bp_s_tready", {31'b0, s_tready}, 32'd0);
         check_eq("bp_hold_tvalid", {31'b0, m_tvalid}, 32'd1);
         check_eq("bp_hold_tdata", m_tdata, 32'h3F80_0000);
         check_eq("bp_hold_tuser", {28'b0, m_tuser}, 32'h1);
         check_eq("bp_hold_count", {16'b0, frame_count}, 32'd6);
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      @(posedge aclk); #1;
      check_eq("bp_count", {16'b0, frame_count}, 32'd7);
      check_eq("bp_tvalid_drop", {31'b0, m_tvalid}, 32'd0);
      check_eq("bp_s_tready_back", {31'b0, s_tready}, 32'd1);

      // frame_sync discards the partial frame holding the big value at bin 2
      send_beat(0, 1'b0);
      send_beat(0, 1'b0);
      send_beat(32'h4200_0000, 1'b0);
      send_beat(32'h3F80_0000, 1'b1);
      check_eq("sync_no_result", {31'b0, m_tvalid}, 32'd0);
      send_beat(0, 1'b0);
      send_beat(0, 1'b0);
      send_beat(32'h4040_0000, 1'b0);
      send_beat(0, 1'b0);
      send_beat(0, 1'b0);
      send_beat(0, 1'b0);
      check_eq("sync_not_early", {31'b0, m_tvalid}, 32'd0);
      send_beat(0, 1'b0);
      expect_result("sync", 32'h4040_0000, 32'h3, 32'd8);

      // async reset mid-frame, at bin 4
      send_beat(0, 1'b0);
      send_beat(32'h4100_0000, 1'b0);
      send_beat(0, 1'b0);
      send_beat(0, 1'b0);
      areset = 1'b1;
      #2;
      check_eq("arst_mid_tvalid", {31'b0, m_tvalid}, 32'd0);
      check_eq("arst_mid_tdata", m_tdata, 32'd0);
      check_eq("arst_mid_count", {16'b0, frame_count}, 32'd0);
      check_eq("arst_mid_s_tready", {31'b0, s_tready}, 32'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      set_frame(0, 0, 32'h3F80_0000, 0, 0, 0, 0, 0);
      run_frame();
      expect_result("arst_clean1", 32'h3F80_0000, 32'h2, 32'd1);

      // async reset while holding a result
      m_tready = 1'b0;
      set_frame(0, 0, 0, 32'h4000_0000, 32'h7FC0_0000, 0, 0, 0);
      run_frame();
      check_eq("arst_hold_pre", {31'b0, m_tvalid}, 32'd1);
      areset = 1'b1;
      #2;
      check_eq("arst_hold_tvalid", {31'b0, m_tvalid}, 32'd0);
      check_eq("arst_hold_tdata", m_tdata, 32'd0);
      check_eq("arst_hold_tuser", {28'b0, m_tuser}, 32'd0);
      check_eq("arst_hold_count", {16'b0, frame_count}, 32'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      m_tready = 1'b1;
      set_frame(32'h4200_0000, 0, 0, 0, 32'h40A0_0000, 0, 0, 0);
      run_frame();
      expect_result("arst_clean2", 32'h40A0_0000, 32'h4, 32'd1);

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spectral_peak_detect.md
# spectral_peak_detect

Consumes the stream of squared FFT magnitudes produced by the magnitude stage (IEEE-754 single-precision Re²+Im², one word per bin, in natural bin order). Per frame of 2^NFFT_LOG2 bins, it finds the largest magnitude within a programmable bin window and reports it. The result is the peak value, the bin index, and a NaN-seen flag, presented on an AXI4-Stream-style master port. It sits directly downstream of the magnitude stage's adder result port and feeds the pitch/level logic.

## Interface
Parameters:
- NFFT_LOG2, 10, log2 of FFT length N (bins per frame)
- MIN_BIN, 1, lowest bin index included in the search (skips DC)
- MAX_BIN, 512, highest bin index included in the search (inclusive); 0 ≤ MIN_BIN ≤ MAX_BIN ≤ N-1

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_mag_tdata  in  32  squared magnitude, float32
- s_axis_mag_tvalid  in  1  input beat valid
- s_axis_mag_tready  out  1  input beat accepted when tvalid&tready
- frame_sync  in  1  single-cycle resynchronisation pulse
- m_axis_peak_tdata  out  32  peak magnitude, float32
- m_axis_peak_tuser  out  NFFT_LOG2+1  {nan_seen, peak_bin}
- m_axis_peak_tvalid  out  1  result valid
- m_axis_peak_tready  in  1  result consumed when tvalid&tready
- frame_count  out  16  count of results handed off, wraps 0xFFFF→0

## Operation
- States: ACCUM, HOLD. Reset state ACCUM.
- ACCUM:
  - s_axis_mag_tready=1. Each accepted beat takes the bin index from bin_cnt (NFFT_LOG2 bits), then bin_cnt increments.
  - Beat is a candidate if MIN_BIN ≤ bin ≤ MAX_BIN. Invalid candidates are ignored, and set nan_seen if they are NaN (exp=0xFF, mantissa≠0).
  - A candidate with sign=1 is treated as 0.0. The comparison is unsigned on bits[30:0], and +Inf is a valid maximum.
  - Update best_val/best_bin only when strictly greater, so on a tie the lowest bin wins.
  - On the beat accepted with bin_cnt=N-1: latch the result into the output registers, bin_cnt wraps to 0, and go to HOLD.
- HOLD: s_axis_mag_tready=0, m_axis_peak_tvalid=1, outputs stable. On m tvalid&tready, frame_count increments and the block returns to ACCUM.
- Per-frame init: best_val=0x00000000, best_bin=MIN_BIN, nan_seen=0. Init applies at reset, on the final beat of each frame, and on frame_sync.
  - If no candidate exceeds 0.0, the result is 0x00000000 at bin MIN_BIN.
- The final beat's own candidate is included in the latched result (compare-and-latch in the same cycle).
- frame_sync in ACCUM: discard the partial frame, reset the per-frame accumulators, and clear bin_cnt.
  - A beat accepted in the same cycle becomes bin 0 of the new frame and is evaluated.
  - No result is produced for a discarded partial frame.
- frame_sync in HOLD: the pending result is unaffected. The next frame starts at bin 0, which it does anyway.

## Timing
- Reset values (asynchronous, immediate on areset=1, all outputs):
  - s_axis_mag_tready=1 once released; 0 while areset=1
  - m_axis_peak_tvalid=0, m_axis_peak_tdata=0, m_axis_peak_tuser=0, frame_count=0
- Reset mid-frame or mid-HOLD abandons everything; the first beat after release is bin 0.
- Latency: m_axis_peak_tvalid rises on the clock edge that accepts bin N-1, so it is visible the cycle after the last handshake.
- s_axis_mag_tready falls on that same edge. It rises on the edge that completes the output handshake, giving one bubble cycle between frames minimum: N+1 cycles per frame with m_axis_peak_tready tied 1.
- m_axis_peak_tdata/tuser must not change while tvalid=1 and tready=0.
- frame_count updates on the handshake edge.
- s_axis_mag_tvalid may drop at any time; gaps do not advance bin_cnt.

## Test plan
All with NFFT_LOG2=3 (N=8), MIN_BIN=1, MAX_BIN=4, m tready=1 unless stated.
- Basic peak: bins 0..7 = 0x40000000, 0x3F800000, 0, 0x40800000, 0, 0, 0x41000000, 0 → tdata=0x40800000, tuser={0,3'd3}, tvalid the cycle after bin 7 accept, frame_count=1.
- Tie and empty: bins 2 and 4 = 0x41000000, rest 0 → bin 2. Next frame all 0 → tdata=0, bin 1.
- Special values: bin1=0xC0000000, bin2=0x7FC00000, bin3=0x3F800000, bin5=0x7FC00000 → tdata=0x3F800000, bin 3, nan_seen=1. Bin 5 is out of window, so alone it yields nan_seen=0.
- Backpressure: hold m tready=0 for 5 cycles after tvalid → s tready=0 and outputs frozen for 5 cycles. Frame_count increments once, and s tready returns 1 the cycle after handshake.
- frame_sync: 3 beats (bin2=0x42000000), then frame_sync with a beat of 0x3F800000 → that beat is bin 0. The next 7 beats complete the frame, and the result excludes 0x42000000.
- Async reset: assert areset mid-frame (bin 4) and again during HOLD → tvalid/tdata/tuser/frame_count go 0 without a clock edge. The next 8 beats form a clean frame.
